fop_alu_driver: RTL and testbench
=================================

FOP_ALU_DRIVER -- requirements
Module: fop_alu_driver

Interface
REQ-001 SHALL have parameter REP_W, default 6: width of the shift repeat count.
REQ-002 SHALL use one clock and an asynchronous, active-low reset. No other clock or reset exists.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req_valid  input  1  request offered.
REQ-006 req_ready  output  1  request accepted when high together with req_valid.
REQ-007 req_cmd  input  5  ALU command code.
REQ-008 req_a, req_b  input  64 each  operands.
REQ-009 req_rep  input  REP_W  repeat count for shift commands.
REQ-010 rsp_valid  output  1  response available.
REQ-011 rsp_ready  input  1  response consumed when high together with rsp_valid.
REQ-012 rsp_data  output  64  final ALU result.
REQ-013 rsp_flags  output  64  ALU flag word after the operation.
REQ-014 alu_opm  output  7  constant 0.
REQ-015 alu_cmd  output  5  command driven to the combinational ALU.
REQ-016 alu_a, alu_b  output  64 each  operands driven to the ALU.
REQ-017 alu_out  input  64  ALU result.

Function
REQ-018 SHALL implement an FSM with states IDLE, EXEC, FLAGS and RESP.
REQ-019 IDLE: req_ready=1. On handshake, register cmd/a/b into alu_cmd/alu_a/alu_b, load the iteration count n, and go to EXEC.
REQ-020 n SHALL be 1 for non-shift commands, ignoring req_rep.
REQ-021 For shift commands 01010..10000, n SHALL be req_rep, with req_rep=0 treated as 1.
REQ-022 EXEC: each clock edge SHALL capture alu_out into the accumulator and into alu_a, then decrement the count.
REQ-023 EXEC: after the n-th capture, the FSM SHALL go to FLAGS (macro defined) or RESP (macro undefined).
REQ-024 FLAGS: drive alu_cmd=00010 (PASSFLAG) for one cycle, capture alu_out into rsp_flags, then go to RESP.
REQ-025 RESP: rsp_valid=1, with rsp_data and rsp_flags held stable until the rsp_valid and rsp_ready handshake, then go to IDLE.
REQ-026 req_ready SHALL be 0 in every state except IDLE; there is no request buffering.
REQ-027 Latency: rsp_valid SHALL rise n+1 cycles after request acceptance, or n+2 cycles with the macro defined.
REQ-028 Back-to-back requests: the next request SHALL be accepted no earlier than the cycle after the response handshake.
REQ-029 Shift feedback SHALL be exactly 64-bit; bits shifted out are lost and no carry is produced.
REQ-030 Command 00011 (LOADFLAG) SHALL execute once and return alu_out as rsp_data.
REQ-031 Unknown command codes SHALL execute once and return whatever the ALU produces (0).

Reset
REQ-032 On rst_n low, asynchronously: state=IDLE, req_ready=1, rsp_valid=0, rsp_data=0, rsp_flags=0, alu_cmd=00000, alu_a=0, alu_b=0, count=0.
REQ-033 Reset during EXEC, FLAGS or RESP SHALL abort the operation with no response emitted.
REQ-034 After reset release, the first request SHALL be accepted at the first clock edge.

Configuration
REQ-035 Macro FOP_ALU_DRV_FLAGS_EN defined: the FLAGS state exists and rsp_flags carries the flag word masked with 0x71F7F.
REQ-036 FOP_ALU_DRV_FLAGS_EN undefined: no FLAGS state, rsp_flags is tied to 0, and latency is reduced by one cycle.

Structure
REQ-037 Shared package fop_alu_pkg SHALL hold:
- the 5-bit command code constants;
- the flag bit positions (C=8, N=9, V=10, Z=11, L=12, ULE=16, SLT=17, SLE=18);
- the flag mask 0x71F7F;
- the FSM state enum;
- an is_shift(cmd) function.
REQ-038 One sub-module, fop_alu_rep_cnt, SHALL provide the load/decrement/zero-detect repeat counter. The FSM and datapath stay in the top module.

Verification
REQ-039 XOR (00111), a=0xF0F0, b=0x0FF0 -> rsp_data=0xFF00. rsp_valid rises 2 cycles after acceptance (3 with the macro).
REQ-040 LSHIFT0 (01110), a=0x1, rep=4 -> rsp_data=0x10. rsp_valid rises 5 cycles after acceptance (6 with the macro).
REQ-041 RSHIFT1 (01011), a=0, rep=0 -> one iteration, rsp_data=0x8000000000000000.
REQ-042 Macro defined: AND (01000), a=0x5, b=0xA -> rsp_data=0, rsp_flags=0x50800 (Z, ULE and SLE set).
REQ-043 Backpressure: hold rsp_ready=0 for 5 cycles. rsp_valid and rsp_data SHALL stay stable and req_ready=0 throughout; a new request is accepted the cycle after the handshake.
REQ-044 Reset mid-operation: assert rst_n=0 during EXEC of LSHIFT0 rep=10. All outputs return to reset values, and no rsp_valid pulse appears after release.

Source files
------------

// File: rtl/fop_alu_pkg.sv
// Shared definitions for the FOP ALU driver: command codes, flag layout, FSM states.
// FOP_ALU_DRV_FLAGS_EN selects whether the driver fetches the flag word after each operation.
package fop_alu_pkg;

    localparam logic [4:0] CMD_PASSFLAG = 5'b00010;
    localparam logic [4:0] CMD_LOADFLAG = 5'b00011;
    localparam logic [4:0] CMD_ADD      = 5'b00100;
    localparam logic [4:0] CMD_SUB      = 5'b00101;
    localparam logic [4:0] CMD_OR       = 5'b00110;
    localparam logic [4:0] CMD_XOR      = 5'b00111;
    localparam logic [4:0] CMD_AND      = 5'b01000;
    localparam logic [4:0] CMD_NOT      = 5'b01001;
    localparam logic [4:0] CMD_RSHIFT0  = 5'b01010;
    localparam logic [4:0] CMD_RSHIFT1  = 5'b01011;
    localparam logic [4:0] CMD_RSHIFTA  = 5'b01100;
    localparam logic [4:0] CMD_ROTR     = 5'b01101;
    localparam logic [4:0] CMD_LSHIFT0  = 5'b01110;
    localparam logic [4:0] CMD_LSHIFT1  = 5'b01111;
    localparam logic [4:0] CMD_ROTL     = 5'b10000;

    localparam int FLAG_C   = 8;
    localparam int FLAG_N   = 9;
    localparam int FLAG_V   = 10;
    localparam int FLAG_Z   = 11;
    localparam int FLAG_L   = 12;
    localparam int FLAG_ULE = 16;
    localparam int FLAG_SLT = 17;
    localparam int FLAG_SLE = 18;

    // Low seven bits pass through untouched; the named flags complete the mask (0x71F7F).
    localparam logic [63:0] FLAG_MASK = 64'h7F
        | (64'd1 << FLAG_C) | (64'd1 << FLAG_N) | (64'd1 << FLAG_V)
        | (64'd1 << FLAG_Z) | (64'd1 << FLAG_L) | (64'd1 << FLAG_ULE)
        | (64'd1 << FLAG_SLT) | (64'd1 << FLAG_SLE);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        FLAGS = 2'd2,
        RESP  = 2'd3
    } state_t;

    function automatic logic is_shift(input logic [4:0] cmd);
        return (cmd >= CMD_RSHIFT0) && (cmd <= CMD_ROTL);
    endfunction

endpackage

// File: rtl/fop_alu_rep_cnt.sv
// Repeat counter for the ALU driver: loads an iteration count, decrements once per
// executed step and flags the step that brings it to zero.
module fop_alu_rep_cnt #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         last_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o = (cnt_q == W'(1));

endmodule

// File: rtl/fop_alu_driver.sv
// Sequences one request through an external combinational ALU, feeding shift results
// back req_rep times. FOP_ALU_DRV_FLAGS_EN adds a PASSFLAG cycle that captures the flag word.
module fop_alu_driver
    import fop_alu_pkg::*;
#(
    parameter int REP_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    // valid/ready: a transfer happens on a rising edge where both are high; the
    // offering side holds its payload stable until that edge.
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [4:0]       req_cmd,
    input  logic [63:0]      req_a,
    input  logic [63:0]      req_b,
    input  logic [REP_W-1:0] req_rep,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [63:0]      rsp_data,
    output logic [63:0]      rsp_flags,
    output logic [6:0]       alu_opm,
    output logic [4:0]       alu_cmd,
    output logic [63:0]      alu_a,
    output logic [63:0]      alu_b,
    input  logic [63:0]      alu_out,
    output state_t           dbg_state_o
);

    state_t      state_q;
    logic        req_ready_q;
    logic        rsp_valid_q;
    logic [63:0] rsp_data_q;
    logic [4:0]  alu_cmd_q;
    logic [63:0] alu_a_q;
    logic [63:0] alu_b_q;

    logic             cnt_load;
    logic             cnt_dec;
    logic             cnt_last;
    logic [REP_W-1:0] n_load;

    // Non-shift commands run once whatever req_rep says; a zero repeat still runs once.
    always_comb begin
        n_load = REP_W'(1);
        if (is_shift(req_cmd) && (req_rep != '0)) begin
            n_load = req_rep;
        end
    end

    assign cnt_load = (state_q == IDLE) && req_valid;
    assign cnt_dec  = (state_q == EXEC);

    fop_alu_rep_cnt #(.W(REP_W)) u_rep_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (cnt_load),
        .load_val_i (n_load),
        .dec_i      (cnt_dec),
        .last_o     (cnt_last)
    );

`ifdef FOP_ALU_DRV_FLAGS_EN
    logic [63:0] rsp_flags_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            alu_cmd_q   <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
`ifdef FOP_ALU_DRV_FLAGS_EN
            rsp_flags_q <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        alu_cmd_q   <= req_cmd;
                        alu_a_q     <= req_a;
                        alu_b_q     <= req_b;
                        req_ready_q <= 1'b0;
                        state_q     <= EXEC;
                    end
                end
                EXEC: begin
                    // The result becomes the next A operand, so shifts iterate on 64 bits.
                    alu_a_q    <= alu_out;
                    rsp_data_q <= alu_out;
                    if (cnt_last) begin
`ifdef FOP_ALU_DRV_FLAGS_EN
                        alu_cmd_q <= CMD_PASSFLAG;
                        state_q   <= FLAGS;
`else
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
`endif
                    end
                end
`ifdef FOP_ALU_DRV_FLAGS_EN
                FLAGS: begin
                    rsp_flags_q <= alu_out & FLAG_MASK;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
`endif
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready   = req_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign alu_opm     = 7'd0;
    assign alu_cmd     = alu_cmd_q;
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign dbg_state_o = state_q;
`ifdef FOP_ALU_DRV_FLAGS_EN
    assign rsp_flags = rsp_flags_q;
`else
    assign rsp_flags = '0;
`endif

endmodule

// File: tb/tb_fop_alu_driver.sv
// Bench for fop_alu_driver: behavioural ALU, result/flag model, per-cycle compare process.
// Works with FOP_ALU_DRV_FLAGS_EN defined or undefined.
module tb_fop_alu_driver;
  import fop_alu_pkg::*;

  localparam int REP_W = 6;
  localparam logic [63:0] MASK = 64'h71F7F;
`ifdef FOP_ALU_DRV_FLAGS_EN
  localparam int FLAG_LAT = 1;
`else
  localparam int FLAG_LAT = 0;
`endif

  logic             clk;
  logic             rst_n;
  logic             req_valid;
  logic             req_ready;
  logic [4:0]       req_cmd;
  logic [63:0]      req_a;
  logic [63:0]      req_b;
  logic [REP_W-1:0] req_rep;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [63:0]      rsp_data;
  logic [63:0]      rsp_flags;
  logic [6:0]       alu_opm;
  logic [4:0]       alu_cmd;
  logic [63:0]      alu_a;
  logic [63:0]      alu_b;
  logic [63:0]      alu_out;
  state_t           dbg_state;

  int tests = 0;
  int fails = 0;
  logic [63:0] exp_q[$];
  logic [63:0] expf_q[$];
  bit busy = 0;

  fop_alu_driver #(.REP_W(REP_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_cmd     (req_cmd),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_rep     (req_rep),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_flags   (rsp_flags),
    .alu_opm     (alu_opm),
    .alu_cmd     (alu_cmd),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_out     (alu_out),
    .dbg_state_o (dbg_state)
  );

  // ---------------- behavioural ALU (environment) ----------------
  function automatic logic [63:0] flag_word(input logic [63:0] a);
    logic [63:0] f;
    f = '1;
    f[6:0] = a[6:0];
    f[8]  = 1'b0;
    f[9]  = a[63];
    f[10] = 1'b0;
    f[11] = (a == 64'd0);
    f[12] = a[0];
    f[16] = (a == 64'd0);
    f[17] = a[63];
    f[18] = a[63] || (a == 64'd0);
    return f;
  endfunction

  function automatic logic [63:0] alu_fn(input logic [4:0] c, input logic [63:0] a, input logic [63:0] b);
    case (c)
      5'b00010: return flag_word(a);
      5'b00011: return a;
      5'b00100: return a + b;
      5'b00101: return a - b;
      5'b00110: return a | b;
      5'b00111: return a ^ b;
      5'b01000: return a & b;
      5'b01001: return ~a;
      5'b01010: return {1'b0, a[63:1]};
      5'b01011: return {1'b1, a[63:1]};
      5'b01100: return {a[63], a[63:1]};
      5'b01101: return {a[0], a[63:1]};
      5'b01110: return {a[62:0], 1'b0};
      5'b01111: return {a[62:0], 1'b1};
      5'b10000: return {a[62:0], a[63]};
      default:  return 64'd0;
    endcase
  endfunction

  assign alu_out = alu_fn(alu_cmd, alu_a, alu_b);

  // ---------------- reference model ----------------
  function automatic int iterations(input logic [4:0] c, input logic [REP_W-1:0] rep);
    if (c >= 5'd10 && c <= 5'd16) return (rep == 0) ? 1 : int'(rep);
    return 1;
  endfunction

  function automatic logic [63:0] model_data(input logic [4:0] c, input logic [63:0] a,
                                             input logic [63:0] b, input logic [REP_W-1:0] rep);
    logic [63:0] r;
    r = a;
    for (int i = 0; i < iterations(c, rep); i++) r = alu_fn(c, r, b);
    return r;
  endfunction

  function automatic logic [63:0] model_flags(input logic [63:0] r);
`ifdef FOP_ALU_DRV_FLAGS_EN
    return flag_word(r) & MASK;
`else
    return 64'd0 & r;
`endif
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%h, want 0x%h", name, act, exp);
    end
  endtask

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- compare process ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy = 0;
      end else begin
        check("alu_opm", 64'(alu_opm), 64'd0);
        check("req_ready", 64'(req_ready), 64'(!busy));
        if (rsp_valid) begin
          if (exp_q.size() == 0) begin
            check("unexpected rsp_valid", 64'(rsp_valid), 64'd0);
          end else begin
            check("rsp_data", rsp_data, exp_q[0]);
            check("rsp_flags", rsp_flags, expf_q[0]);
            if (rsp_ready) begin
              void'(exp_q.pop_front());
              void'(expf_q.pop_front());
              busy = 0;
            end
          end
        end
        if (req_valid && req_ready) busy = 1;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic send(input string name, input logic [4:0] c, input logic [63:0] a,
                      input logic [63:0] b, input logic [REP_W-1:0] rep, input int hold,
                      input logic [63:0] lit_data);
    int waits;
    int lat;
    logic [63:0] md;
    md = model_data(c, a, b, rep);
    check({name, " model"}, md, lit_data);
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_cmd   = c;
    req_a     = a;
    req_b     = b;
    req_rep   = rep;
    rsp_ready = (hold == 0);
    waits = 0;
    forever begin
      @(negedge clk);
      if (req_ready) break;
      waits++;
      if (waits > 100) begin
        check({name, " accept timeout"}, 64'd1, 64'd0);
        req_valid = 1'b0;
        return;
      end
    end
    exp_q.push_back(md);
    expf_q.push_back(model_flags(md));
    check({name, " accept_wait"}, 64'(waits), 64'd0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 1;
    forever begin
      @(negedge clk);
      if (rsp_valid) break;
      lat++;
      if (lat > 300) begin
        check({name, " response timeout"}, 64'd1, 64'd0);
        return;
      end
    end
    check({name, " latency"}, 64'(lat), 64'(iterations(c, rep) + 1 + FLAG_LAT));
    if (hold > 0) begin
      repeat (hold - 1) @(negedge clk);
      @(posedge clk);
      #1;
      rsp_ready = 1'b1;
      @(negedge clk);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit seen;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_cmd   = '0;
    req_a     = '0;
    req_b     = '0;
    req_rep   = '0;
    rsp_ready = 1'b1;
    #12;
    check("reset req_ready", 64'(req_ready), 64'd1);
    check("reset rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset rsp_data", rsp_data, 64'd0);
    check("reset rsp_flags", rsp_flags, 64'd0);
    check("reset alu_cmd", 64'(alu_cmd), 64'd0);
    check("reset alu_a", alu_a, 64'd0);
    check("reset alu_b", alu_b, 64'd0);
    check("reset state", 64'(dbg_state), 64'(IDLE));
`ifdef FOP_ALU_DRV_FLAGS_EN
    check("and flags model", model_flags(64'd0), 64'h50800);
`endif
    @(posedge clk);
    #3;
    rst_n = 1'b1;

    send("xor",        5'b00111, 64'hF0F0, 64'h0FF0, 6'd0, 0, 64'hFF00);
    send("lshift0 x4", 5'b01110, 64'h1, 64'h0, 6'd4, 0, 64'h10);
    send("rshift1 r0", 5'b01011, 64'h0, 64'h0, 6'd0, 0, 64'h8000_0000_0000_0000);
    send("and",        5'b01000, 64'h5, 64'hA, 6'd0, 0, 64'h0);
    send("add wrap",   5'b00100, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2, 6'd0, 0, 64'h1);
    send("lshift lost",5'b01110, 64'h8000_0000_0000_0001, 64'h0, 6'd1, 0, 64'h2);
    send("add rep7",   5'b00100, 64'h3, 64'h4, 6'd7, 0, 64'h7);
    send("rshift0 x4", 5'b01010, 64'hF0, 64'h0, 6'd4, 0, 64'hF);
    send("not rep4",   5'b01001, 64'h0, 64'h0, 6'd4, 0, 64'hFFFF_FFFF_FFFF_FFFF);
    send("cmd 10001",  5'b10001, 64'h5, 64'h6, 6'd5, 0, 64'h0);
    send("cmd 11111",  5'b11111, 64'h5, 64'h6, 6'd0, 0, 64'h0);
    send("loadflag",   5'b00011, 64'h12345, 64'h0, 6'd0, 0, 64'h12345);
    send("rotl x2",    5'b10000, 64'h8000_0000_0000_0000, 64'h0, 6'd2, 0, 64'h2);
    send("rshifta x3", 5'b01100, 64'h8000_0000_0000_0000, 64'h0, 6'd3, 0, 64'hF000_0000_0000_0000);
    send("lshift x63", 5'b01110, 64'h1, 64'h0, 6'd63, 0, 64'h8000_0000_0000_0000);
    send("backpress",  5'b00111, 64'hFF, 64'h0F, 6'd0, 5, 64'hF0);
    send("b2b lshift1",5'b01111, 64'h0, 64'h0, 6'd3, 0, 64'h7);
    send("rotr",       5'b01101, 64'h1, 64'h0, 6'd1, 0, 64'h8000_0000_0000_0000);
    send("sub",        5'b00101, 64'h0, 64'h1, 6'd0, 0, 64'hFFFF_FFFF_FFFF_FFFF);

    // Abort a long shift mid-execution; no response may follow.
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_cmd   = 5'b01110;
    req_a     = 64'h1;
    req_b     = 64'h0;
    req_rep   = 6'd10;
    @(negedge clk);
    check("abort accept", 64'(req_ready), 64'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort in exec", 64'(dbg_state), 64'(EXEC));
    #2;
    rst_n = 1'b0;
    #1;
    check("abort req_ready", 64'(req_ready), 64'd1);
    check("abort rsp_valid", 64'(rsp_valid), 64'd0);
    check("abort rsp_data", rsp_data, 64'd0);
    check("abort rsp_flags", rsp_flags, 64'd0);
    check("abort alu_cmd", 64'(alu_cmd), 64'd0);
    check("abort alu_a", alu_a, 64'd0);
    check("abort alu_b", alu_b, 64'd0);
    check("abort state", 64'(dbg_state), 64'(IDLE));
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (rsp_valid) seen = 1;
    end
    check("no rsp after abort", 64'(seen), 64'd0);

    send("post-reset xor", 5'b00111, 64'h1234, 64'h00FF, 6'd0, 0, 64'h12CB);
    repeat (3) @(negedge clk);
    check("queue drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
